// File: rtl/apb_pkg.sv
// Shared APB definitions.
//   apb_mst_state_e : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   APB_ADDR_W/DATA_W : default bus widths
//   apb_rsp_t       : response bundle {rdata, slverr, timeout}, also used by the slave-side bench
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: turns one valid/ready command into one APB transfer
// (SETUP then ACCESS) and returns the result on a valid/ready response channel.
// A wait-state counter aborts the transfer after TIMEOUT ACCESS cycles
// without pready.
//
// Ports:
//   pclk, preset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready decoded from state)
//   cmd_write/cmd_addr/cmd_wdata command fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_slverr/rsp_timeout  response fields
//   psel/penable/pwrite/paddr/pwdata  APB request signals (registered)
//   prdata/pready/pslverr        APB completion signals from the slave
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    apb_mst_state_e    state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [DATA_W-1:0] pwdata_nx;
    logic              rsp_valid_nx, rsp_slverr_nx, rsp_timeout_nx;
    logic [DATA_W-1:0] rsp_rdata_nx;

    // Masked by preset so that every output reads 0 while reset is held.
    assign cmd_ready = (state == IDLE) && !preset;

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        psel_nx        = psel;
        penable_nx     = penable;
        pwrite_nx      = pwrite;
        paddr_nx       = paddr;
        pwdata_nx      = pwdata;
        rsp_valid_nx   = rsp_valid;
        rsp_rdata_nx   = rsp_rdata;
        rsp_slverr_nx  = rsp_slverr;
        rsp_timeout_nx = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx  = SETUP;
                    psel_nx   = 1'b1;
                    pwrite_nx = cmd_write;
                    paddr_nx  = cmd_addr;
                    pwdata_nx = cmd_wdata;
                end
            end
            SETUP: begin
                state_nx   = ACCESS;
                penable_nx = 1'b1;
                cnt_nx     = '0;
            end
            ACCESS: begin
                // pready wins over an expiring counter in the same cycle.
                if (pready) begin
                    state_nx       = RESP;
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = pwrite ? '0 : prdata;
                    rsp_slverr_nx  = pslverr;
                    rsp_timeout_nx = 1'b0;
                end else if (cnt == CNT_MAX) begin
                    state_nx       = RESP;
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = '0;
                    rsp_slverr_nx  = 1'b1;
                    rsp_timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            psel        <= psel_nx;
            penable     <= penable_nx;
            pwrite      <= pwrite_nx;
            paddr       <= paddr_nx;
            pwdata      <= pwdata_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_slverr  <= rsp_slverr_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Requester end of the APB bus: accepts simple valid/ready read/write commands and drives one APB transfer per command (SETUP then ACCESS).
- Returns read data and error status on a valid/ready response channel.
- Sits between the testbench or SoC command fabric and the APB slave signals (paddr, pwrite, pwdata, psel, penable, prdata, pready, pslverr).
- Adds a bounded wait-state timeout so that a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 32, address width of cmd_addr and paddr.
- DATA_W, 32, data width of cmd_wdata, pwdata, prdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles without pready before the transfer is aborted; must be at least 1.

Ports:
- pclk  in  1  bus clock; all state changes on its rising edge.
- preset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_slverr  out  1  pslverr seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset:
  - One clock (pclk); reset preset is asynchronous and active-high.
  - While preset is high, every output is 0 and the state is IDLE.
  - A reset during any state aborts the transfer immediately; no response is produced.
- All outputs are registered, except cmd_ready, which is decoded from the state.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On accept: latch cmd_write into pwrite, cmd_addr into paddr, cmd_wdata into pwdata; go to SETUP.
- SETUP:
  - psel=1, penable=0, cmd_ready=0; lasts exactly one cycle; go to ACCESS.
  - Clear the wait counter.
- ACCESS:
  - psel=1, penable=1.
  - If pready=1: capture rsp_rdata = prdata for reads or 0 for writes; rsp_slverr = pslverr; rsp_timeout=0. Go to RESP with psel=0 and penable=0.
  - If pready=0: increment the wait counter.
  - Timeout: when the counter reaches TIMEOUT-1 and pready is still 0, go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, and drop psel/penable.
  - pready=1 on the timeout cycle takes priority over the timeout (normal completion).
- RESP:
  - rsp_valid=1; rsp fields held stable until rsp_ready=1; then go to IDLE with rsp_valid=0.
  - cmd_ready=0 throughout, so there is never more than one outstanding command.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS, and hold their values after the transfer until the next accept.
- pslverr and prdata are sampled only in the ACCESS cycle where pready=1; they are ignored otherwise.
- Latency:
  - Accept at edge N; psel at N+1; penable at N+2.
  - With zero wait states, rsp_valid at N+3.
  - Each wait state adds one cycle.
  - Minimum command-to-command spacing is 4 cycles, including a same-cycle rsp_ready.
- Wait counter width: $clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - default ADDR_W/DATA_W localparams;
  - response struct {rdata, slverr, timeout}, reused by the slave-side bench.
- No sub-module: the FSM, counter and capture registers fit in one module.

Test Plan:
- Write, zero wait: cmd write addr 0x10, data 0xDEADBEEF; pready=1 in the first ACCESS cycle -> psel high 2 cycles, penable high 1 cycle, paddr=0x10 and pwdata=0xDEADBEEF stable; rsp_valid at accept+3 with rsp_slverr=0, rsp_rdata=0.
- Read, 3 wait states: addr 0x24, slave returns prdata=0xCAFEF00D on the 4th ACCESS cycle -> penable high 4 cycles; rsp_rdata=0xCAFEF00D, rsp_slverr=0, rsp_timeout=0.
- Slave error: write addr 0x40 with pslverr=1 alongside pready -> rsp_slverr=1, rsp_timeout=0; the next command is accepted normally.
- Timeout, TIMEOUT=16: pready held 0 -> exactly 16 ACCESS cycles, then psel=penable=0; rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. A second run with pready=1 on the 16th cycle -> normal completion.
- Response backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp fields stable, cmd_ready=0, psel=0 throughout; rsp_ready=1 -> IDLE next cycle and cmd_ready=1.
- Reset mid-ACCESS: assert preset between clock edges -> all outputs 0 without waiting for a clock edge; after release, no rsp_valid, and a new read completes correctly.
